// File: rtl/blk_out_stq.sv
// Store-queue output stage: packs merged output elements into STQ lines, buffers them in a
// small line FIFO and issues them in order at consecutive line addresses from DRAM_OFFSET.
module blk_out_stq #(
    parameter int   DRAM_OFFSET                = 0,
    parameter int   STORE_ADDR_WIDTH           = 16,
    parameter int   STORE_ADDR_ALIGNMENT_WIDTH = 6,
    parameter int   DRAM_ADDR_WIDTH            = STORE_ADDR_WIDTH + STORE_ADDR_ALIGNMENT_WIDTH,
    parameter int   STQ_DATA_WIDTH             = 512,
    parameter int   DATA_WIDTH_OUTPUT          = 64,
    parameter int   ELEMS_PER_LINE             = STQ_DATA_WIDTH / DATA_WIDTH_OUTPUT,
    parameter int   STQ_BUF_DEPTH              = 4,
    parameter logic MODE_WORK                  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         unit_en,
    input  logic                         mode,
    input  logic                         out_valid,
    input  logic [DATA_WIDTH_OUTPUT-1:0] out_data,
    input  logic                         out_last,
    output logic                         out_ready,
    output logic                         stq_valid,
    input  logic                         stq_ready,
    output logic [DRAM_ADDR_WIDTH-1:0]   stq_addr,
    output logic [STQ_DATA_WIDTH-1:0]    stq_data,
    output logic [ELEMS_PER_LINE-1:0]    stq_elem_mask,
    output logic [STORE_ADDR_WIDTH-1:0]  lines_stored,
    output logic                         done
);

    localparam int SW = $clog2(ELEMS_PER_LINE);
    localparam int PW = $clog2(STQ_BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = DATA_WIDTH_OUTPUT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [SW-1:0]               slot_q, slot_d;
    logic [STQ_DATA_WIDTH-1:0]   pack_data_q, pack_data_d;
    logic [ELEMS_PER_LINE-1:0]   pack_mask_q, pack_mask_d;
    logic [STQ_DATA_WIDTH-1:0]   mem_data_q [STQ_BUF_DEPTH];
    logic [ELEMS_PER_LINE-1:0]   mem_mask_q [STQ_BUF_DEPTH];
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic [STORE_ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [STORE_ADDR_WIDTH-1:0] lines_stored_q, lines_stored_d;
    logic                        done_q, done_d;

    logic                        active_s, accept_s, push_s, pop_s;
    logic [STQ_DATA_WIDTH-1:0]   line_s;
    logic [ELEMS_PER_LINE-1:0]   mask_s;

    assign active_s  = unit_en && (mode == MODE_WORK);
    assign out_ready = active_s && (state_q == ST_FILL) && (count_q < CW'(STQ_BUF_DEPTH));
    assign accept_s  = out_valid && out_ready;
    assign push_s    = accept_s && (out_last || (slot_q == SW'(ELEMS_PER_LINE - 1)));
    assign stq_valid = (count_q != '0);
    assign pop_s     = stq_valid && stq_ready;

    // Current packer contents with the incoming element merged into its slot (slot 0 at the MSB).
    always_comb begin
        line_s = pack_data_q;
        mask_s = pack_mask_q;
        for (int k = 0; k < ELEMS_PER_LINE; k++) begin
            line_s[STQ_DATA_WIDTH-1-k*DW -: DW] = (slot_q == SW'(k)) ? out_data
                                                : pack_data_q[STQ_DATA_WIDTH-1-k*DW -: DW];
            mask_s[ELEMS_PER_LINE-1-k] = (slot_q == SW'(k)) ? 1'b1 : pack_mask_q[ELEMS_PER_LINE-1-k];
        end
    end

    // Packer next state: clear after a line is handed to the FIFO, else accumulate.
    always_comb begin
        slot_d      = slot_q;
        pack_data_d = pack_data_q;
        pack_mask_d = pack_mask_q;
        if (push_s) begin
            slot_d      = '0;
            pack_data_d = '0;
            pack_mask_d = '0;
        end else if (accept_s) begin
            slot_d      = slot_q + SW'(1);
            pack_data_d = line_s;
            pack_mask_d = mask_s;
        end else begin
            slot_d      = slot_q;
            pack_data_d = pack_data_q;
            pack_mask_d = pack_mask_q;
        end
    end

    // FIFO pointers, occupancy and STQ-side address/line counters.
    always_comb begin
        wr_ptr_d       = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d       = pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
        line_addr_d    = pop_s ? line_addr_q + STORE_ADDR_WIDTH'(1) : line_addr_q;
        lines_stored_d = pop_s ? lines_stored_q + STORE_ADDR_WIDTH'(1) : lines_stored_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = active_s ? ST_FILL : ST_IDLE;
            ST_FILL:  state_d = (accept_s && out_last) ? ST_DRAIN : ST_FILL;
            ST_DRAIN: state_d = (count_q == '0) ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM output logic.
    always_comb begin
        done_d = (state_q == ST_DONE);
    end

    // State register and all control/counter registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q        <= ST_IDLE;
            slot_q         <= '0;
            pack_data_q    <= '0;
            pack_mask_q    <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            line_addr_q    <= STORE_ADDR_WIDTH'(DRAM_OFFSET);
            lines_stored_q <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            pack_data_q    <= pack_data_d;
            pack_mask_q    <= pack_mask_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            line_addr_q    <= line_addr_d;
            lines_stored_q <= lines_stored_d;
            done_q         <= done_d;
        end
    end

    // Line storage; outputs are masked while empty so stale entries never reach the port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_data_q[wr_ptr_q] <= line_s;
            mem_mask_q[wr_ptr_q] <= mask_s;
        end
    end

    assign stq_addr      = stq_valid ? {line_addr_q, {STORE_ADDR_ALIGNMENT_WIDTH{1'b0}}} : '0;
    assign stq_data      = stq_valid ? mem_data_q[rd_ptr_q] : '0;
    assign stq_elem_mask = stq_valid ? mem_mask_q[rd_ptr_q] : '0;
    assign lines_stored  = lines_stored_q;
    assign done          = done_q;

endmodule

// File: tb/tb_blk_out_stq.sv
// Directed bench for blk_out_stq: table of stream lengths plus hand-written backpressure,
// simultaneous push/pop, enable-drop and mid-stream reset sequences.
module tb_blk_out_stq;

    localparam int W   = 512;
    localparam int DW  = 64;
    localparam int E   = 8;
    localparam int SAW = 16;
    localparam int AW  = 22;
    localparam int OFF = 16;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          unit_en = 1'b0;
    logic          mode = 1'b0;
    logic          out_valid = 1'b0;
    logic [DW-1:0] out_data = '0;
    logic          out_last = 1'b0;
    logic          out_ready;
    logic          stq_valid;
    logic          stq_ready = 1'b0;
    logic [AW-1:0] stq_addr;
    logic [W-1:0]  stq_data;
    logic [E-1:0]  stq_elem_mask;
    logic [SAW-1:0] lines_stored;
    logic          done;

    blk_out_stq #(.DRAM_OFFSET(OFF)) dut (
        .clk(clk), .rst_b(rst_b), .unit_en(unit_en), .mode(mode),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .stq_valid(stq_valid), .stq_ready(stq_ready), .stq_addr(stq_addr), .stq_data(stq_data),
        .stq_elem_mask(stq_elem_mask), .lines_stored(lines_stored), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [AW-1:0] cap_addr[$];
    logic [W-1:0]  cap_data[$];
    logic [E-1:0]  cap_mask[$];

    typedef struct {
        int          n;
        int          lines;
        logic [7:0]  last_mask;
        logic [63:0] l0_low;
    } vec_t;

    // Record every STQ handshake that will complete at the next rising edge.
    always @(negedge clk) begin
        #2;
        if (rst_b && stq_valid && stq_ready) begin
            cap_addr.push_back(stq_addr);
            cap_data.push_back(stq_data);
            cap_mask.push_back(stq_elem_mask);
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_line(input int l, input int n);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < E; i++)
            if (l * E + i + 1 <= n) r[W-1-i*DW -: DW] = 64'(l * E + i + 1);
        return r;
    endfunction

    function automatic logic [E-1:0] exp_mask(input int l, input int n);
        logic [E-1:0] r;
        r = '0;
        for (int i = 0; i < E; i++)
            if (l * E + i + 1 <= n) r[E-1-i] = 1'b1;
        return r;
    endfunction

    task automatic check_lines(input string tag, input int n, input int nlines);
        chk({tag, "_nlines"}, W'(cap_data.size()), W'(nlines));
        for (int l = 0; l < nlines; l++) begin
            if (l < cap_data.size()) begin
                chk($sformatf("%s_addr%0d", tag, l), W'(cap_addr[l]), W'((OFF + l) << 6));
                chk($sformatf("%s_data%0d", tag, l), cap_data[l], exp_line(l, n));
                chk($sformatf("%s_mask%0d", tag, l), W'(cap_mask[l]), W'(exp_mask(l, n)));
            end
        end
    endtask

    // Offer values first..last_val; stop after max_acc accepts or max_cyc cycles.
    task automatic send(input int first, input int last_val, input int max_acc,
                        input int max_cyc, output int acc);
        int v;
        int cyc;
        acc = 0;
        cyc = 0;
        v = first;
        while (v <= last_val && acc < max_acc && cyc < max_cyc) begin
            @(negedge clk);
            out_valid = 1'b1;
            out_data  = 64'(v);
            out_last  = (v == last_val);
            #1;
            if (out_ready) begin
                acc++;
                v++;
            end
            cyc++;
        end
        @(negedge clk);
        out_valid = 1'b0;
        out_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int c;
        c = 0;
        while (!done && c < bound) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_done"}, W'(done), W'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b = 1'b0;
        unit_en = 1'b0;
        mode = 1'b0;
        out_valid = 1'b0;
        out_last = 1'b0;
        stq_ready = 1'b0;
        repeat (2) @(negedge clk);
        cap_addr.delete();
        cap_data.delete();
        cap_mask.delete();
        rst_b = 1'b1;
    endtask

    initial begin
        vec_t tbl[5];
        int acc;
        logic [AW-1:0] a_hold;
        logic [W-1:0]  d_hold;

        tbl[0] = '{16, 2, 8'hFF, 64'd8};
        tbl[1] = '{11, 2, 8'hE0, 64'd8};
        tbl[2] = '{8,  1, 8'hFF, 64'd8};
        tbl[3] = '{1,  1, 8'h80, 64'd0};
        tbl[4] = '{9,  2, 8'h80, 64'd8};

        #12;
        chk("rst_stq_valid", W'(stq_valid), W'(0));
        chk("rst_out_ready", W'(out_ready), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_lines", W'(lines_stored), W'(0));
        chk("rst_addr", W'(stq_addr), W'(0));

        for (int t = 0; t < 5; t++) begin
            do_reset();
            unit_en = 1'b1;
            mode = 1'b1;
            stq_ready = 1'b1;
            send(1, tbl[t].n, tbl[t].n, 200, acc);
            chk($sformatf("v%0d_acc", t), W'(acc), W'(tbl[t].n));
            wait_done($sformatf("v%0d", t), 50);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_lines_stored", t), W'(lines_stored), W'(tbl[t].lines));
            if (cap_data.size() >= tbl[t].lines) begin
                chk($sformatf("v%0d_last_mask", t), W'(cap_mask[tbl[t].lines-1]), W'(tbl[t].last_mask));
                chk($sformatf("v%0d_l0_hi", t), W'(cap_data[0][W-1 -: DW]), W'(1));
                chk($sformatf("v%0d_l0_lo", t), W'(cap_data[0][DW-1:0]), W'(tbl[t].l0_low));
            end
            check_lines($sformatf("v%0d", t), tbl[t].n, tbl[t].lines);
        end

        // Backpressure: four lines fill the FIFO, input stalls, head stays stable.
        do_reset();
        unit_en = 1'b1;
        mode = 1'b1;
        send(1, 40, 8, 50, acc);
        chk("bp_first8", W'(acc), W'(8));
        chk("bp_latency_valid", W'(stq_valid), W'(1));
        send(9, 40, 32, 60, acc);
        chk("bp_next24", W'(acc), W'(24));
        send(33, 40, 8, 10, acc);
        chk("bp_stalled", W'(acc), W'(0));
        chk("bp_out_ready", W'(out_ready), W'(0));
        a_hold = stq_addr;
        d_hold = stq_data;
        repeat (3) @(negedge clk);
        chk("bp_addr", W'(stq_addr), W'(OFF << 6));
        chk("bp_addr_stable", W'(stq_addr), W'(a_hold));
        chk("bp_data_stable", stq_data, d_hold);
        stq_ready = 1'b1;
        send(33, 40, 8, 100, acc);
        chk("bp_rest", W'(acc), W'(8));
        wait_done("bp", 50);
        check_lines("bp", 40, 5);
        chk("bp_lines_stored", W'(lines_stored), W'(5));

        // Push and pop in the same cycle with three lines queued.
        do_reset();
        unit_en = 1'b1;
        mode = 1'b1;
        send(1, 40, 31, 100, acc);
        chk("pp_first31", W'(acc), W'(31));
        @(negedge clk);
        stq_ready = 1'b1;
        out_valid = 1'b1;
        out_data = 64'd32;
        out_last = 1'b0;
        #1;
        chk("pp_out_ready", W'(out_ready), W'(1));
        @(negedge clk);
        stq_ready = 1'b0;
        out_valid = 1'b0;
        #3;
        chk("pp_one_popped", W'(cap_data.size()), W'(1));
        send(33, 40, 8, 30, acc);
        chk("pp_room_after", W'(acc), W'(8));
        stq_ready = 1'b1;
        wait_done("pp", 50);
        check_lines("pp", 40, 5);

        // Enable drop with a partial line held in the packer.
        do_reset();
        unit_en = 1'b1;
        mode = 1'b1;
        send(1, 24, 21, 100, acc);
        chk("en_first21", W'(acc), W'(21));
        unit_en = 1'b0;
        stq_ready = 1'b1;
        #1;
        chk("en_out_ready", W'(out_ready), W'(0));
        repeat (6) @(negedge clk);
        chk("en_drained", W'(cap_data.size()), W'(2));
        chk("en_valid_low", W'(stq_valid), W'(0));
        unit_en = 1'b1;
        send(22, 24, 3, 50, acc);
        chk("en_rest", W'(acc), W'(3));
        wait_done("en", 50);
        check_lines("en", 24, 3);

        // Asynchronous reset mid-stream, then a clean restart.
        do_reset();
        unit_en = 1'b1;
        mode = 1'b1;
        send(1, 40, 10, 50, acc);
        @(negedge clk);
        #3;
        rst_b = 1'b0;
        #1;
        chk("ar_stq_valid", W'(stq_valid), W'(0));
        chk("ar_out_ready", W'(out_ready), W'(0));
        chk("ar_done", W'(done), W'(0));
        chk("ar_lines", W'(lines_stored), W'(0));
        @(negedge clk);
        cap_addr.delete();
        cap_data.delete();
        cap_mask.delete();
        rst_b = 1'b1;
        stq_ready = 1'b1;
        send(1, 8, 8, 50, acc);
        wait_done("ar", 50);
        check_lines("ar", 8, 1);
        chk("ar_lines_stored", W'(lines_stored), W'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
